// File: rtl/fetch.sv
// Instruction fetch stage: sequential PC generation, in-order word reads and a small {inst, pc} buffer.
// Optional build macro FETCH_STALL_COUNT_EN adds the stall_cycles / empty_cycles counters.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        fetch_stall,
    input  logic        flush,
    input  logic [31:0] flush_pc
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] empty_cycles
`endif
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [CW:0]   live_total;
    logic [CW:0]   flight_total;
    logic          req_fire;
    logic          live_resp;
    logic          push;
    logic          pop;

    always_comb begin
        live_total     = {1'b0, fcnt} + {1'b0, outstanding};
        flight_total   = {1'b0, outstanding} + {1'b0, drop};
        imem_req_valid = ~reset & ~flush & (live_total < DEPTH_W) & (flight_total < DEPTH_W);
    end

    assign imem_req_addr = pc;
    assign redirect_pc   = flush_pc & 32'hFFFF_FFFC;
    assign req_fire      = imem_req_valid & imem_req_ready;
    // Responses to requests issued before a flush are consumed by drop first; only the rest are live.
    assign live_resp     = imem_resp_valid & (drop == '0);
    assign push          = live_resp & ~flush;
    assign inst_valid    = fcnt != '0;
    assign pop           = inst_valid & ~fetch_stall & ~flush;
    assign inst          = fifo_inst[rd_ptr];
    assign inst_pc       = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            fcnt        <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (flush) begin
            pc          <= redirect_pc;
            resp_pc     <= redirect_pc;
            fcnt        <= '0;
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(imem_resp_valid);
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (imem_resp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            case ({req_fire, live_resp})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            // Live responses return in request order, so their PCs are simply sequential from resp_pc.
            if (push) begin
                fifo_inst[wr_ptr] <= imem_resp_data;
                fifo_pc[wr_ptr]   <= resp_pc;
                wr_ptr            <= wr_ptr + AW'(1);
                resp_pc           <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fcnt <= fcnt + CW'(1);
                2'b01:   fcnt <= fcnt - CW'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            empty_cycles <= '0;
        end else begin
            if (inst_valid && fetch_stall && !flush && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (!inst_valid && !flush && (empty_cycles != '1)) begin
                empty_cycles <= empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
